// File: rtl/jk_pkg.sv
// Shared types for the JK excitation driver: FSM state encoding and the
// two-bit {J,K} excitation codes.
package jk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_CHECK = 2'd2,
    ST_ERROR = 2'd3
  } jk_state_e;

  localparam logic [1:0] EXC_HOLD = 2'b00;
  localparam logic [1:0] EXC_SET  = 2'b10;
  localparam logic [1:0] EXC_CLR  = 2'b01;
  localparam logic [1:0] EXC_TGL  = 2'b11;

endpackage

// File: rtl/jk_excite_driver_if.sv
// Command and bank-facing signals of the JK excitation driver. The master is
// the controller plus JK bank; the slave is the driver itself.
interface jk_excite_driver_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] q_fb;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic             done;
  logic             error;
  logic             err_clear;

  modport master (
    output in_valid, target, q_fb, err_clear,
    input  in_ready, j, k, done, error
  );

  modport slave (
    input  in_valid, target, q_fb, err_clear,
    output in_ready, j, k, done, error
  );
endinterface

// File: rtl/jk_excite_bit.sv
// Single-bit JK excitation: maps current q and desired t to a {J,K} code.
// Unchanged bits always hold; changing bits set/clear or toggle.
module jk_excite_bit
  import jk_pkg::*;
(
  input  logic       i_q,
  input  logic       i_t,
  input  logic       i_toggle_mode,
  output logic [1:0] o_jk
);

  always_comb begin
    // NOTE: default first so every path assigns o_jk and no latch is inferred.
    o_jk = EXC_HOLD;
    if (i_q != i_t) begin
      if (i_toggle_mode) o_jk = EXC_TGL;
      else               o_jk = i_t ? EXC_SET : EXC_CLR;
    end
  end

endmodule

// File: rtl/jk_excite_driver.sv
// Drives one clock of J/K excitation into a JK flip-flop bank, reads q back,
// retries a bounded number of times and latches a sticky error on failure.
module jk_excite_driver
  import jk_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int MAX_RETRY   = 2,
  parameter int TOGGLE_MODE = 0
) (
  input  logic               clock,
  input  logic               reset,
  jk_excite_driver_if.slave  bus
);

  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);

  jk_state_e        r_state;
  jk_state_e        w_state_next;
  logic [WIDTH-1:0] r_tgt;
  logic [WIDTH-1:0] r_j;
  logic [WIDTH-1:0] r_k;
  logic [RW-1:0]    r_retry;
  logic             r_done;
  logic             r_error;
  logic             r_in_ready;

  logic [WIDTH-1:0] w_tgt_sel;
  logic [WIDTH-1:0] w_j;
  logic [WIDTH-1:0] w_k;
  logic [1:0]       w_exc [WIDTH];
  logic             w_accept;
  logic             w_match;
  logic             w_can_retry;

  // Excitation targets the incoming word while idle, the latched word on retry.
  assign w_tgt_sel   = (r_state == ST_IDLE) ? bus.target : r_tgt;
  assign w_accept    = (r_state == ST_IDLE) && r_in_ready && bus.in_valid;
  assign w_match     = (bus.q_fb == r_tgt);
  assign w_can_retry = (r_retry < RETRY_LIMIT);

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    jk_excite_bit u_bit (
      .i_q           (bus.q_fb[gi]),
      .i_t           (w_tgt_sel[gi]),
      .i_toggle_mode (TOGGLE_MODE != 0),
      .o_jk          (w_exc[gi])
    );
    assign w_j[gi] = w_exc[gi][1];
    assign w_k[gi] = w_exc[gi][0];
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_state_next = ST_DRIVE;
      ST_DRIVE: w_state_next = ST_CHECK;
      ST_CHECK: begin
        if (w_match)          w_state_next = ST_IDLE;
        else if (w_can_retry) w_state_next = ST_DRIVE;
        else                  w_state_next = ST_ERROR;
      end
      ST_ERROR: if (bus.err_clear) w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_tgt      <= '0;
      r_j        <= '0;
      r_k        <= '0;
      r_retry    <= '0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_in_ready <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values.
      r_state    <= w_state_next;
      r_in_ready <= (w_state_next == ST_IDLE);
      r_done     <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_tgt   <= bus.target;
            r_j     <= w_j;
            r_k     <= w_k;
            r_retry <= '0;
          end
        end
        ST_DRIVE: begin
          r_j <= '0;
          r_k <= '0;
        end
        ST_CHECK: begin
          if (w_match) begin
            r_done <= 1'b1;
          end else if (w_can_retry) begin
            r_retry <= r_retry + 1'b1;
            r_j     <= w_j;
            r_k     <= w_k;
          end else begin
            r_error <= 1'b1;
          end
        end
        ST_ERROR: begin
          if (bus.err_clear) r_error <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready = r_in_ready;
  assign bus.j        = r_j;
  assign bus.k        = r_k;
  assign bus.done     = r_done;
  assign bus.error    = r_error;

endmodule

// File: tb/tb_jk_excite_driver.sv
// Bench for jk_excite_driver: two instances (set/clear and toggle mode) each
// driving a JK bank model, with a done-driven scoreboard and corner sequences.
module tb_jk_excite_driver;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en1 = 1'b0;
  logic [3:0] stuck = 4'b0000;
  logic [3:0] bank0;
  logic [3:0] bank1;
  int         cyc = 0;
  int         n_tests = 0;
  int         n_fail = 0;

  typedef struct {
    logic [3:0] q;
    int         acc;
    bit         dual;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    logic [3:0] tgt;
    logic [3:0] j0;
    logic [3:0] k0;
    logic [3:0] j1;
    logic [3:0] k1;
  } vec_t;
  vec_t vecs[5];

  jk_excite_driver_if #(.WIDTH(4)) bus0();
  jk_excite_driver_if #(.WIDTH(4)) bus1();

  jk_excite_driver #(.WIDTH(4), .MAX_RETRY(2), .TOGGLE_MODE(0)) dut0 (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus0)
  );

  jk_excite_driver #(.WIDTH(4), .MAX_RETRY(2), .TOGGLE_MODE(1)) dut1 (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus1)
  );

  assign bus0.q_fb      = bank0 & ~stuck;
  assign bus1.q_fb      = bank1;
  assign bus1.in_valid  = bus0.in_valid & en1;
  assign bus1.target    = bus0.target;
  assign bus1.err_clear = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank0 <= '0;
      bank1 <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        case ({bus0.j[i], bus0.k[i]})
          2'b10: bank0[i] <= 1'b1;
          2'b01: bank0[i] <= 1'b0;
          2'b11: bank0[i] <= ~bank0[i];
          default: ;
        endcase
        case ({bus1.j[i], bus1.k[i]})
          2'b10: bank1[i] <= 1'b1;
          2'b01: bank1[i] <= 1'b0;
          2'b11: bank1[i] <= ~bank1[i];
          default: ;
        endcase
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Waits (bounded) for in_ready, presents the word and returns the accept cycle.
  task automatic accept(input logic [3:0] t, output int acc);
    bit ready_seen = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (bus0.in_ready) begin
        ready_seen = 1'b1;
        break;
      end
    end
    check("in_ready_timeout", 32'(ready_seen), 32'd1);
    bus0.in_valid = 1'b1;
    bus0.target   = t;
    @(posedge clk);
    #1;
    acc = cyc;
    bus0.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 20; n++) begin
      if (sb_q.size() == 0) break;
      @(negedge clk);
    end
    check("scoreboard_drain", 32'(sb_q.size()), 32'd0);
  endtask

  always @(negedge clk) begin
    if (bus0.done && bus0.error) check("done_error_exclusive", {30'd0, bus0.done, bus0.error}, 32'h2);
    if (bus0.done) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 expected no pending write (t=%0t)", $time);
      end else begin
        sb_t e;
        e = sb_q.pop_front();
        check("bank0_after_done", 32'(bank0), 32'(e.q));
        check("done_latency", 32'(cyc - e.acc), 32'd2);
        check("done_in_ready", 32'(bus0.in_ready), 32'd1);
        if (e.dual) begin
          check("done1_pulse", 32'(bus1.done), 32'd1);
          check("bank1_after_done", 32'(bank1), 32'(e.q));
        end
      end
    end
  end

  initial begin
    int acc;
    int drives;
    int err_at;

    vecs[0] = '{tgt: 4'b1010, j0: 4'b1010, k0: 4'b0000, j1: 4'b1010, k1: 4'b1010};
    vecs[1] = '{tgt: 4'b0110, j0: 4'b0100, k0: 4'b1000, j1: 4'b1100, k1: 4'b1100};
    vecs[2] = '{tgt: 4'b0110, j0: 4'b0000, k0: 4'b0000, j1: 4'b0000, k1: 4'b0000};
    vecs[3] = '{tgt: 4'b1001, j0: 4'b1001, k0: 4'b0110, j1: 4'b1111, k1: 4'b1111};
    vecs[4] = '{tgt: 4'b0000, j0: 4'b0000, k0: 4'b1001, j1: 4'b1001, k1: 4'b1001};

    bus0.in_valid  = 1'b0;
    bus0.target    = 4'b0000;
    bus0.err_clear = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(bus0.in_ready), 32'd0);
    check("rst_jk", {24'd0, bus0.j, bus0.k}, 32'd0);
    check("rst_done_error", {30'd0, bus0.done, bus0.error}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_release", 32'(bus0.in_ready), 32'd1);

    // Table: back-to-back writes on both excitation modes
    en1 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      accept(vecs[i].tgt, acc);
      sb_q.push_back('{q: vecs[i].tgt, acc: acc, dual: 1'b1});
      @(negedge clk);
      check($sformatf("v%0d_j0", i), 32'(bus0.j), 32'(vecs[i].j0));
      check($sformatf("v%0d_k0", i), 32'(bus0.k), 32'(vecs[i].k0));
      check($sformatf("v%0d_j1", i), 32'(bus1.j), 32'(vecs[i].j1));
      check($sformatf("v%0d_k1", i), 32'(bus1.k), 32'(vecs[i].k1));
    end
    drain();
    en1 = 1'b0;
    check("tgl_error_clean", 32'(bus1.error), 32'd0);

    // Stuck-at-0 feedback bit: three drive phases, then sticky error
    stuck = 4'b0001;
    accept(4'b0001, acc);
    drives = 0;
    err_at = -1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bus0.j != 4'b0000) drives++;
      if (bus0.error) begin
        err_at = cyc - acc;
        break;
      end
    end
    check("retry_drive_phases", 32'(drives), 32'd3);
    check("error_cycle", 32'(err_at), 32'd6);
    repeat (2) @(negedge clk);
    check("error_sticky", 32'(bus0.error), 32'd1);
    check("error_not_ready", 32'(bus0.in_ready), 32'd0);
    check("error_jk_zero", {24'd0, bus0.j, bus0.k}, 32'd0);
    bus0.err_clear = 1'b1;
    @(posedge clk);
    #1;
    bus0.err_clear = 1'b0;
    @(negedge clk);
    check("err_clear_error", 32'(bus0.error), 32'd0);
    check("err_clear_ready", 32'(bus0.in_ready), 32'd1);
    bus0.err_clear = 1'b1;
    @(posedge clk);
    #1;
    bus0.err_clear = 1'b0;
    @(negedge clk);
    check("idle_err_clear_ready", 32'(bus0.in_ready), 32'd1);
    check("idle_err_clear_flags", {30'd0, bus0.done, bus0.error}, 32'd0);
    stuck = 4'b0000;

    // Async reset in the middle of DRIVE
    accept(4'b0000, acc);
    sb_q.push_back('{q: 4'b0000, acc: acc, dual: 1'b0});
    @(negedge clk);
    check("clr_k0", 32'(bus0.k), 32'h1);
    accept(4'b1111, acc);
    @(negedge clk);
    check("pre_reset_j", 32'(bus0.j), 32'hf);
    rst_n = 1'b0;
    #1;
    check("reset_jk_zero", {24'd0, bus0.j, bus0.k}, 32'd0);
    check("reset_flags", {30'd0, bus0.done, bus0.error}, 32'd0);
    check("reset_not_ready", 32'(bus0.in_ready), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_midreset", 32'(bus0.in_ready), 32'd1);

    // in_valid held through CHECK with a second word
    accept(4'b0101, acc);
    sb_q.push_back('{q: 4'b0101, acc: acc, dual: 1'b0});
    @(negedge clk);
    check("held_a_j", 32'(bus0.j), 32'h5);
    bus0.in_valid = 1'b1;
    bus0.target   = 4'b0011;
    @(negedge clk);
    check("held_check_not_ready", 32'(bus0.in_ready), 32'd0);
    @(negedge clk);
    check("held_done_ready", 32'(bus0.in_ready), 32'd1);
    @(posedge clk);
    #1;
    sb_q.push_back('{q: 4'b0011, acc: cyc, dual: 1'b0});
    bus0.in_valid = 1'b0;
    @(negedge clk);
    check("held_b_j", 32'(bus0.j), 32'h2);
    check("held_b_k", 32'(bus0.k), 32'h4);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
